// File: rtl/clint.sv
// Core-local interrupt controller: sequences trap entry / mret CSR writes.
// Ports: clk/rst, trap flags + PCs in, CSR values in; hold, CSR write, PC redirect out.
module clint #(
  parameter int unsigned     DW           = 32,
  parameter logic [DW-1:0]   CAUSE_ECALL  = DW'(32'd11),
  parameter logic [DW-1:0]   CAUSE_EBREAK = DW'(32'd3),
  parameter logic [DW-1:0]   CAUSE_INT    = DW'(32'h8000_0007)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          I_ecall,
  input  logic          I_ebreak,
  input  logic          I_mret,
  input  logic [DW-1:0] I_inst_addr,
  input  logic          I_jump_flag,
  input  logic [DW-1:0] I_jump_addr,
  input  logic          I_int_req,
  input  logic [DW-1:0] I_csr_mtvec,
  input  logic [DW-1:0] I_csr_mepc,
  input  logic [DW-1:0] I_csr_mstatus,
  input  logic          I_global_int_en,
  output logic          O_hold_flag,
  output logic          O_we,
  output logic [11:0]   O_waddr,
  output logic [DW-1:0] O_wdata,
  output logic          O_int_assert,
  output logic [DW-1:0] O_int_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_MEPC,
    S_W_MCAUSE,
    S_W_MSTATUS,
    S_W_MRET,
    S_ASSERT
  } state_e;

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;

  state_e        state_q, state_d;
  logic [DW-1:0] mepc_q, mepc_d;
  logic [DW-1:0] cause_q, cause_d;
  // ASSERT is shared; this remembers whether it returns to mepc or traps to mtvec.
  logic          mret_q, mret_d;

  logic sync_req;
  logic async_req;
  logic any_req;

  assign sync_req  = I_ecall | I_ebreak;
  assign async_req = I_int_req & I_global_int_en;
  assign any_req   = sync_req | I_mret | async_req;

  logic [DW-1:0] mst_trap;
  logic [DW-1:0] mst_mret;

  // Trap: MPIE <= MIE, MIE <= 0.  mret: MIE <= MPIE, MPIE <= 1.
  always_comb begin
    mst_trap    = I_csr_mstatus;
    mst_trap[7] = I_csr_mstatus[3];
    mst_trap[3] = 1'b0;
    mst_mret    = I_csr_mstatus;
    mst_mret[3] = I_csr_mstatus[7];
    mst_mret[7] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    mepc_d  = mepc_q;
    cause_d = cause_q;
    mret_d  = mret_q;
    unique case (state_q)
      S_IDLE: begin
        if (sync_req) begin
          state_d = S_W_MEPC;
          mepc_d  = I_inst_addr;
          cause_d = I_ecall ? CAUSE_ECALL : CAUSE_EBREAK;
          mret_d  = 1'b0;
        end else if (I_mret) begin
          state_d = S_W_MRET;
          mret_d  = 1'b1;
        end else if (async_req) begin
          state_d = S_W_MEPC;
          mepc_d  = I_jump_flag ? I_jump_addr : I_inst_addr;
          cause_d = CAUSE_INT;
          mret_d  = 1'b0;
        end
      end
      S_W_MEPC:    state_d = S_W_MCAUSE;
      S_W_MCAUSE:  state_d = S_W_MSTATUS;
      S_W_MSTATUS: state_d = S_ASSERT;
      S_W_MRET:    state_d = S_ASSERT;
      S_ASSERT:    state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mepc_q  <= '0;
      cause_q <= '0;
      mret_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mepc_q  <= mepc_d;
      cause_q <= cause_d;
      mret_q  <= mret_d;
    end
  end

  // Outputs are forced low while rst is high so an aborted
  // sequence never leaks a write or redirect.
  always_comb begin
    O_hold_flag  = 1'b0;
    O_we         = 1'b0;
    O_waddr      = '0;
    O_wdata      = '0;
    O_int_assert = 1'b0;
    O_int_addr   = '0;
    if (!rst) begin
      O_hold_flag = (state_q != S_IDLE) | any_req;
      unique case (state_q)
        S_W_MEPC: begin
          O_we    = 1'b1;
          O_waddr = A_MEPC;
          O_wdata = mepc_q;
        end
        S_W_MCAUSE: begin
          O_we    = 1'b1;
          O_waddr = A_MCAUSE;
          O_wdata = cause_q;
        end
        S_W_MSTATUS: begin
          O_we    = 1'b1;
          O_waddr = A_MSTATUS;
          O_wdata = mst_trap;
        end
        S_W_MRET: begin
          O_we    = 1'b1;
          O_waddr = A_MSTATUS;
          O_wdata = mst_mret;
        end
        S_ASSERT: begin
          O_int_assert = 1'b1;
          O_int_addr   = mret_q ? I_csr_mepc
                                : {I_csr_mtvec[DW-1:2], 2'b00};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_clint.sv
// Scoreboard bench for clint: per-cycle expected outputs are queued
// when inputs are driven and compared on the falling edge.
module tb_clint;

  logic        clk = 1'b0;
  logic        rst;
  logic        ecall, ebreak, mret;
  logic [31:0] inst_addr;
  logic        jump_flag;
  logic [31:0] jump_addr;
  logic        int_req;
  logic [31:0] mtvec, mepc, mstatus;
  logic        mie;
  logic        hold, we, ia;
  logic [11:0] waddr;
  logic [31:0] wdata, iaddr;

  clint dut (
    .clk            (clk),
    .rst            (rst),
    .I_ecall        (ecall),
    .I_ebreak       (ebreak),
    .I_mret         (mret),
    .I_inst_addr    (inst_addr),
    .I_jump_flag    (jump_flag),
    .I_jump_addr    (jump_addr),
    .I_int_req      (int_req),
    .I_csr_mtvec    (mtvec),
    .I_csr_mepc     (mepc),
    .I_csr_mstatus  (mstatus),
    .I_global_int_en(mie),
    .O_hold_flag    (hold),
    .O_we           (we),
    .O_waddr        (waddr),
    .O_wdata        (wdata),
    .O_int_assert   (ia),
    .O_int_addr     (iaddr)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        hold;
    logic        we;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic        ia;
    logic [31:0] iaddr;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      check({e.tag, ".hold"},  {31'd0, hold}, {31'd0, e.hold});
      check({e.tag, ".we"},    {31'd0, we},   {31'd0, e.we});
      check({e.tag, ".waddr"}, {20'd0, waddr}, {20'd0, e.waddr});
      check({e.tag, ".wdata"}, wdata, e.wdata);
      check({e.tag, ".ia"},    {31'd0, ia},   {31'd0, e.ia});
      check({e.tag, ".iaddr"}, iaddr, e.iaddr);
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic h, input logic w,
                      input logic [11:0] a, input logic [31:0] d,
                      input logic i, input logic [31:0] ta);
    exp_t e;
    e.tag = tag; e.hold = h; e.we = w; e.waddr = a;
    e.wdata = d; e.ia = i; e.iaddr = ta;
    sbq.push_back(e);
  endtask

  task automatic idle0(input string tag);
    push(tag, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic clr();
    ecall = 0; ebreak = 0; mret = 0; jump_flag = 0;
    int_req = 0; mie = 0; rst = 0;
  endtask

  // Caller drives the detecting cycle's inputs first; inputs stay put.
  task automatic trap_seq(input string tag, input logic [31:0] ep,
                          input logic [31:0] ca, input logic [31:0] ms,
                          input logic [31:0] tgt);
    push({tag, ".det"}, 1'b1, 1'b0, 12'h0, 32'h0, 1'b0, 32'h0);
    nxt(); push({tag, ".mepc"},  1'b1, 1'b1, 12'h341, ep, 1'b0, 32'h0);
    nxt(); push({tag, ".mcause"},1'b1, 1'b1, 12'h342, ca, 1'b0, 32'h0);
    nxt(); push({tag, ".mstat"}, 1'b1, 1'b1, 12'h300, ms, 1'b0, 32'h0);
    nxt(); push({tag, ".assert"},1'b1, 1'b0, 12'h0, 32'h0, 1'b1, tgt);
  endtask

  task automatic mret_seq(input string tag, input logic [31:0] ms,
                          input logic [31:0] tgt);
    push({tag, ".det"}, 1'b1, 1'b0, 12'h0, 32'h0, 1'b0, 32'h0);
    nxt(); push({tag, ".mstat"}, 1'b1, 1'b1, 12'h300, ms, 1'b0, 32'h0);
    nxt(); push({tag, ".assert"},1'b1, 1'b0, 12'h0, 32'h0, 1'b1, tgt);
  endtask

  initial begin
    clr();
    rst = 1;
    inst_addr = 0; jump_addr = 0;
    mtvec = 0; mepc = 0; mstatus = 0;
    nxt(); idle0("rst0");
    nxt(); ecall = 1; idle0("rst_req");
    nxt(); clr(); idle0("post_rst");

    // ecall
    nxt();
    ecall = 1; inst_addr = 32'h8000_0010;
    mtvec = 32'h8000_0100; mstatus = 32'h8;
    trap_seq("ecall", 32'h8000_0010, 32'd11, 32'h80, 32'h8000_0100);
    nxt(); clr(); idle0("ecall.after");

    // interrupt via jump target; mtvec low bits masked
    nxt();
    int_req = 1; mie = 1; jump_flag = 1;
    jump_addr = 32'h8000_0040; inst_addr = 32'h8000_0020;
    mtvec = 32'h8000_0103; mstatus = 32'h1888;
    trap_seq("irq_j", 32'h8000_0040, 32'h8000_0007, 32'h1880,
             32'h8000_0100);
    nxt(); mie = 0; idle0("irq_j.masked");

    // interrupt without jump uses inst_addr
    nxt();
    mie = 1; jump_flag = 0; inst_addr = 32'h8000_0024;
    mtvec = 32'h8000_0200; mstatus = 32'h0;
    trap_seq("irq_pc", 32'h8000_0024, 32'h8000_0007, 32'h0,
             32'h8000_0200);
    nxt(); clr(); idle0("irq_pc.after");

    // masked interrupt
    nxt(); int_req = 1; mie = 0; idle0("mie0.a");
    nxt(); idle0("mie0.b");
    nxt(); clr(); idle0("mie0.c");

    // mret
    nxt();
    mret = 1; mstatus = 32'h80; mepc = 32'h8000_0014;
    mret_seq("mret", 32'h88, 32'h8000_0014);
    nxt(); clr(); idle0("mret.after");

    // mret restoring MIE=0; mret beats a pending interrupt
    nxt();
    mret = 1; int_req = 1; mie = 1;
    mstatus = 32'hF008; mepc = 32'h0000_1234;
    mret_seq("mret2", 32'hF080, 32'h0000_1234);
    nxt(); clr(); idle0("mret2.after");

    // ebreak with simultaneous interrupt
    nxt();
    ebreak = 1; int_req = 1; mie = 1;
    inst_addr = 32'h8000_0030; mtvec = 32'h8000_0100;
    mstatus = 32'h8;
    trap_seq("ebrk", 32'h8000_0030, 32'd3, 32'h80, 32'h8000_0100);
    nxt(); ebreak = 0; mie = 0; idle0("ebrk.noint");
    nxt(); clr(); idle0("ebrk.after");

    // ecall + ebreak together
    nxt();
    ecall = 1; ebreak = 1; inst_addr = 32'h0000_0400;
    mtvec = 32'h0000_0800; mstatus = 32'h0;
    trap_seq("both", 32'h0000_0400, 32'd11, 32'h0, 32'h0000_0800);
    nxt(); clr(); idle0("both.after");

    // reset during W_MCAUSE aborts
    nxt();
    ecall = 1; inst_addr = 32'h8000_0050;
    mtvec = 32'h8000_0100; mstatus = 32'h8;
    push("abort.det", 1'b1, 1'b0, 12'h0, 32'h0, 1'b0, 32'h0);
    nxt();
    push("abort.mepc", 1'b1, 1'b1, 12'h341, 32'h8000_0050, 1'b0, 32'h0);
    nxt(); ecall = 0; rst = 1; idle0("abort.rst");
    nxt(); clr(); idle0("abort.idle1");
    nxt(); idle0("abort.idle2");
    nxt();
    ecall = 1; inst_addr = 32'h8000_0060;
    trap_seq("reecall", 32'h8000_0060, 32'd11, 32'h80, 32'h8000_0100);
    nxt(); clr(); idle0("reecall.after");

    nxt(); nxt();
    check("sb_drain", sbq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
